serial_adder_fsm: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_fsm_fa_slice.sv | 14 +
 rtl/serial_adder_fsm.sv | 145 ++++++++++++++
 tb/tb_serial_adder_fsm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial adder.
// The SERIAL_ADDER_SUB_EN build option is handled in serial_adder_fsm.sv.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_steps(input int width, input int bits_per_cycle);
      return width / bits_per_cycle;
   endfunction

   // The counter only has to reach STEPS-1, but it always needs at least one bit.
   function automatic int calc_cnt_w(input int width, input int bits_per_cycle);
      int steps;
      steps = width / bits_per_cycle;
      return (steps <= 2) ? 1 : $clog2(steps);
   endfunction

endpackage

// File: rtl/serial_adder_fsm_fa_slice.sv
// One-bit full adder.
// A chain of these forms the per-cycle adder in serial_adder_fsm.
module fa_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (b & cin) | (a & cin);

endmodule

// File: rtl/serial_adder_fsm.sv
// Multi-cycle adder that adds BITS_PER_CYCLE bits per clock, LSB first, with a registered carry.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port, which computes a-b.
module serial_adder_fsm
   import serial_adder_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
   localparam int CNT_W = calc_cnt_w(WIDTH, BITS_PER_CYCLE);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   generate
      if (BITS_PER_CYCLE < 1 || WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
         $error("serial_adder_fsm: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   state_t              state;
   state_t              next_state;
   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;
   logic                carry_reg;
   logic [CNT_W-1:0]    cnt;
   logic [WIDTH-1:0]    sum_reg;
   logic                cout_reg;
   logic                ovf_reg;

   logic [WIDTH-1:0]    b_in;
   logic                cin_in;
   logic                accept;
   logic                last_step;

   logic [BITS_PER_CYCLE-1:0] chain_sum;
   logic [BITS_PER_CYCLE:0]   chain_c;
   logic [WIDTH-1:0]          sum_shift;

   // Subtraction is a + ~b + 1, so invert b and force the carry-in at latch time.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_in   = sub ? ~b : b;
   assign cin_in = sub | cin;
`else
   assign b_in   = b;
   assign cin_in = cin;
`endif

   assign chain_c[0] = carry_reg;

   generate
      for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
         fa_slice u_fa (
            .a    (a_reg[i]),
            .b    (b_reg[i]),
            .cin  (chain_c[i]),
            .sum  (chain_sum[i]),
            .cout (chain_c[i+1])
         );
      end
   endgenerate

   // Each step's result bits enter at the MSB end, so after STEPS shifts the word is in place.
   assign sum_shift = (sum_reg >> BITS_PER_CYCLE) | (WIDTH'(chain_sum) << (WIDTH - BITS_PER_CYCLE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST_STEP) begin
               last_step  = 1'b1;
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (accept) begin
         a_reg     <= a;
         b_reg     <= b_in;
         carry_reg <= cin_in;
         cnt       <= '0;
         sum_reg   <= '0;
      end else if (state == RUN) begin
         a_reg     <= a_reg >> BITS_PER_CYCLE;
         b_reg     <= b_reg >> BITS_PER_CYCLE;
         carry_reg <= chain_c[BITS_PER_CYCLE];
         sum_reg   <= sum_shift;
         cnt       <= cnt + CNT_W'(1);
         // On the final step the top slice holds the word's MSB.
         if (last_step) begin
            cout_reg <= chain_c[BITS_PER_CYCLE];
            ovf_reg  <= chain_c[BITS_PER_CYCLE] ^ chain_c[BITS_PER_CYCLE-1];
         end
      end
   end

   assign busy     = (state == RUN);
   assign done     = (state == DONE);
   assign sum      = sum_reg;
   assign cout     = cout_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm: 8-bit instances at 1 and 4 bits per cycle,
// plus a 2-bit-per-cycle subtract instance when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub;
`endif

   logic       start1, start4;
   logic       busy1, done1, cout1, ovf1;
   logic [7:0] sum1;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] sum4;

   int checks   = 0;
   int failures = 0;
   int cur      = 1;

   logic       obs_busy, obs_done, obs_cout, obs_ovf;
   logic [7:0] obs_sum;

   always #5 clk = ~clk;

   serial_adder_fsm #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
   );

   serial_adder_fsm #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
   );

`ifdef SERIAL_ADDER_SUB_EN
   logic       start2;
   logic       busy2, done2, cout2, ovf2;
   logic [7:0] sum2;

   serial_adder_fsm #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
   );
`endif

   // Route the instance under test onto one set of observation signals.
   always_comb begin
      obs_busy = busy1;
      obs_done = done1;
      obs_sum  = sum1;
      obs_cout = cout1;
      obs_ovf  = ovf1;
      if (cur == 4) begin
         obs_busy = busy4;
         obs_done = done4;
         obs_sum  = sum4;
         obs_cout = cout4;
         obs_ovf  = ovf4;
      end
`ifdef SERIAL_ADDER_SUB_EN
      if (cur == 2) begin
         obs_busy = busy2;
         obs_done = done2;
         obs_sum  = sum2;
         obs_cout = cout2;
         obs_ovf  = ovf2;
      end
`endif
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic setStart(input int unit, input logic v);
      if (unit == 1) start1 = v;
      if (unit == 4) start4 = v;
`ifdef SERIAL_ADDER_SUB_EN
      if (unit == 2) start2 = v;
`endif
   endtask

   // lat counts negedges after the accepting edge until done is seen (bounded).
   task automatic applyStimulus(input int unit, input logic [7:0] av, input logic [7:0] bv,
                                input logic cv, output int lat, output int busycnt);
      cur = unit;
      @(negedge clk);
      a   = av;
      b   = bv;
      cin = cv;
      setStart(unit, 1'b1);
      @(negedge clk);
      setStart(unit, 1'b0);
      lat     = 0;
      busycnt = 0;
      while (obs_done !== 1'b1 && lat < 40) begin
         if (obs_busy === 1'b1) busycnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int bc;
      int n;
      int seen;

      rst    = 1'b1;
      start1 = 1'b0;
      start4 = 1'b0;
      a      = 8'h00;
      b      = 8'h00;
      cin    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      start2 = 1'b0;
      sub    = 1'b0;
`endif
      #1;
      checkOutput("rst_busy", busy1, 0);
      checkOutput("rst_done", done1, 0);
      checkOutput("rst_sum", sum1, 0);
      checkOutput("rst_cout", cout1, 0);
      checkOutput("rst_ovf", ovf1, 0);
      checkOutput("rst_done4", done4, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      $display("[TB] 0x5A + 0x3C, one bit per cycle");
      applyStimulus(1, 8'h5A, 8'h3C, 1'b0, lat, bc);
      checkOutput("t1_done", obs_done, 1);
      checkOutput("t1_latency", lat, 8);
      checkOutput("t1_busy_cycles", bc, 8);
      checkOutput("t1_busy_at_done", obs_busy, 0);
      checkOutput("t1_sum", obs_sum, 8'h96);
      checkOutput("t1_cout", obs_cout, 0);
      checkOutput("t1_ovf", obs_ovf, 1);
      @(negedge clk);
      checkOutput("t1_done_pulse", obs_done, 0);
      checkOutput("t1_sum_hold", obs_sum, 8'h96);

      $display("[TB] reset during RUN");
      cur = 1;
      @(negedge clk);
      a      = 8'h5A;
      b      = 8'h3C;
      cin    = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("mid_busy", busy1, 1);
      checkOutput("mid_partial_sum", sum1, 8'h60);
      checkOutput("mid_ovf_held", ovf1, 1);
      rst = 1'b1;
      #1;
      checkOutput("mrst_busy", busy1, 0);
      checkOutput("mrst_done", done1, 0);
      checkOutput("mrst_sum", sum1, 0);
      checkOutput("mrst_cout", cout1, 0);
      checkOutput("mrst_ovf", ovf1, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done1 === 1'b1 || busy1 === 1'b1) seen++;
      end
      checkOutput("mrst_no_done", seen, 0);

      applyStimulus(1, 8'h01, 8'h02, 1'b0, lat, bc);
      checkOutput("t2_done", obs_done, 1);
      checkOutput("t2_latency", lat, 8);
      checkOutput("t2_sum", obs_sum, 8'h03);
      checkOutput("t2_cout", obs_cout, 0);

      applyStimulus(1, 8'hFF, 8'h01, 1'b0, lat, bc);
      checkOutput("t3_done", obs_done, 1);
      checkOutput("t3_sum", obs_sum, 8'h00);
      checkOutput("t3_cout", obs_cout, 1);
      checkOutput("t3_ovf", obs_ovf, 0);

      applyStimulus(1, 8'h00, 8'h00, 1'b1, lat, bc);
      checkOutput("t4_done", obs_done, 1);
      checkOutput("t4_sum", obs_sum, 8'h01);
      checkOutput("t4_cout", obs_cout, 0);

      $display("[TB] start held through RUN, b changed at E3");
      cur = 1;
      @(negedge clk);
      a      = 8'h5A;
      b      = 8'h3C;
      cin    = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      b = 8'h11;
      n = 3;
      while (done1 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("hold_done", done1, 1);
      checkOutput("hold_latency", n, 8);
      checkOutput("hold_sum", sum1, 8'h96);
      checkOutput("hold_ovf", ovf1, 1);
      @(negedge clk);
      checkOutput("hold_single_done", done1, 0);
      checkOutput("hold_idle_busy", busy1, 0);
      @(negedge clk);
      checkOutput("hold_reaccept_busy", busy1, 1);
      checkOutput("hold_sum_cleared", sum1, 8'h00);
      checkOutput("hold_ovf_kept", ovf1, 1);
      start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("hold2_done", done1, 1);
      checkOutput("hold2_sum", sum1, 8'h6B);
      checkOutput("hold2_ovf", ovf1, 0);
      checkOutput("hold2_cout", cout1, 0);

      $display("[TB] 0x7F + 0x01, four bits per cycle");
      applyStimulus(4, 8'h7F, 8'h01, 1'b0, lat, bc);
      checkOutput("w4_done", obs_done, 1);
      checkOutput("w4_latency", lat, 2);
      checkOutput("w4_busy_cycles", bc, 2);
      checkOutput("w4_sum", obs_sum, 8'h80);
      checkOutput("w4_cout", obs_cout, 0);
      checkOutput("w4_ovf", obs_ovf, 1);

`ifdef SERIAL_ADDER_SUB_EN
      $display("[TB] subtract, two bits per cycle");
      sub = 1'b1;
      applyStimulus(2, 8'h10, 8'h01, 1'b0, lat, bc);
      checkOutput("sub1_done", obs_done, 1);
      checkOutput("sub1_latency", lat, 4);
      checkOutput("sub1_sum", obs_sum, 8'h0F);
      checkOutput("sub1_cout", obs_cout, 1);
      checkOutput("sub1_ovf", obs_ovf, 0);
      applyStimulus(2, 8'h00, 8'h01, 1'b0, lat, bc);
      checkOutput("sub2_done", obs_done, 1);
      checkOutput("sub2_sum", obs_sum, 8'hFF);
      checkOutput("sub2_cout", obs_cout, 0);
      sub = 1'b0;
      applyStimulus(2, 8'h10, 8'h01, 1'b0, lat, bc);
      checkOutput("sub0_sum", obs_sum, 8'h11);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
